// File: rtl/mult_pkg.sv
// Shared types and limits for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WORK = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int MULT_WIDTH_MAX = 32;

endpackage

// File: rtl/mult_pp_gen.sv
// Partial-product generator: extends the multiplicand to 2*WIDTH bits (sign or zero),
// gates it with the current multiplier bit and aligns it to the step position.
module mult_pp_gen
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   a,
  input  logic               b_bit,
  input  logic [CNT_W-1:0]   ctr,
  input  logic               sgn,
  output logic [2*WIDTH-1:0] pp
);

  logic [2*WIDTH-1:0] ext;

  always_comb begin
    if (sgn) begin
      ext = {{WIDTH{a[WIDTH-1]}}, a};
    end else begin
      ext = {{WIDTH{1'b0}}, a};
    end
    if (b_bit) begin
      pp = ext << ctr;
    end else begin
      pp = '0;
    end
  end

endmodule

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier, unsigned or two's-complement, one multiplier bit per clock.
// Optional MULT_SEQ_EARLY_EXIT_EN ends the run once no higher multiplier bits remain set.
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WIDTH-1:0]     a_bi,
  input  logic [WIDTH-1:0]     b_bi,
  input  logic                 signed_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 valid_o,
  output logic [2*WIDTH-1:0]   y_bo
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   ctr;
  logic [WIDTH-1:0]   a_lat;
  logic [WIDTH-1:0]   b_lat;
  logic               sgn_lat;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] pp;
  logic [2*WIDTH-1:0] y_reg;
  logic               busy_reg;
  logic               valid_reg;
  logic               top_step;
  logic               last_step;

  mult_pp_gen #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_pp_gen (
    .a     (a_lat),
    .b_bit (b_lat[ctr]),
    .ctr   (ctr),
    .sgn   (sgn_lat),
    .pp    (pp)
  );

  always_comb begin
    state_next = state;
    top_step   = (ctr == CNT_W'(WIDTH - 1));
`ifdef MULT_SEQ_EARLY_EXIT_EN
    last_step  = top_step || (((b_lat >> ctr) >> 1'b1) == '0);
`else
    last_step  = top_step;
`endif
    // The sign bit of a two's-complement multiplier carries weight -2^(WIDTH-1).
    if (sgn_lat && top_step) begin
      acc_next = acc - pp;
    end else begin
      acc_next = acc + pp;
    end
    case (state)
      IDLE: begin
        if (start_i) begin
          state_next = WORK;
        end else begin
          state_next = IDLE;
        end
      end
      WORK: begin
        if (last_step) begin
          state_next = DONE;
        end else begin
          state_next = WORK;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      ctr       <= '0;
      a_lat     <= '0;
      b_lat     <= '0;
      sgn_lat   <= 1'b0;
      acc       <= '0;
      y_reg     <= '0;
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      state     <= state_next;
      busy_reg  <= (state_next != IDLE);
      valid_reg <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start_i) begin
            a_lat   <= a_bi;
            b_lat   <= b_bi;
            sgn_lat <= signed_i;
            acc     <= '0;
            ctr     <= '0;
          end
        end
        WORK: begin
          if (last_step) begin
            y_reg <= acc_next;
          end else begin
            acc <= acc_next;
            ctr <= ctr + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy_o  = busy_reg;
  assign valid_o = valid_reg;
  assign y_bo    = y_reg;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed table at WIDTH=8, multi-cycle corner
// sequences, and a random sweep at WIDTH=3/8/16 against an arithmetic reference.
module tb_mult_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start8, sgn8, busy8, valid8;
  logic [7:0]  a8, b8;
  logic [15:0] y8;
  logic        start_x, sgn_x, busy3, valid3, busy16, valid16;
  logic [2:0]  a3, b3;
  logic [5:0]  y3;
  logic [15:0] a16, b16;
  logic [31:0] y16;

  mult_seq #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .a_bi(a8), .b_bi(b8), .signed_i(sgn8),
    .start_i(start8), .busy_o(busy8), .valid_o(valid8), .y_bo(y8));
  mult_seq #(.WIDTH(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .a_bi(a3), .b_bi(b3), .signed_i(sgn_x),
    .start_i(start_x), .busy_o(busy3), .valid_o(valid3), .y_bo(y3));
  mult_seq #(.WIDTH(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .a_bi(a16), .b_bi(b16), .signed_i(sgn_x),
    .start_i(start_x), .busy_o(busy16), .valid_o(valid16), .y_bo(y16));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference product: interpret operands as integers, multiply, wrap to 2*w bits.
  function automatic longint ref_prod(input int w, input longint a, input longint b, input bit s);
    longint sa = a;
    longint sb = b;
    if (s && a[w-1]) sa = a - (longint'(1) << w);
    if (s && b[w-1]) sb = b - (longint'(1) << w);
    return (sa * sb) & ((longint'(1) << (2 * w)) - 1);
  endfunction

  // Expected number of WORK cycles.
  function automatic int lat(input int w, input longint b, input bit s);
    int n = 1;
`ifdef MULT_SEQ_EARLY_EXIT_EN
    if (s && b[w-1]) return w;
    for (int i = 0; i < w; i++) if (b[i]) n = i + 1;
    return n;
`else
    n = w;
    return n;
`endif
  endfunction

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     output longint y, output int vedge, output int vcount, output int bcount);
    @(negedge clk);
    a8 = a; b8 = b; sgn8 = s; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
    vedge = -1; vcount = 0; bcount = 0; y = 0;
    if (busy8) bcount++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (valid8) begin
        vcount++;
        if (vedge < 0) begin vedge = k; y = longint'(y8); end
      end
      if (busy8) bcount++;
      else break;
    end
  endtask

  task automatic sweep(input logic s);
    longint ea3, eb3, ea16, eb16, r3, r16;
    int e3, e16;
    @(negedge clk);
    a3 = 3'($urandom); b3 = 3'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
    sgn_x = s; start_x = 1'b1;
    ea3 = longint'(a3); eb3 = longint'(b3); ea16 = longint'(a16); eb16 = longint'(b16);
    @(posedge clk); #1;
    start_x = 1'b0; a3 = 3'($urandom); b3 = 3'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
    e3 = -1; e16 = -1; r3 = 0; r16 = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (valid3 && e3 < 0) begin e3 = k; r3 = longint'(y3); end
      if (valid16 && e16 < 0) begin e16 = k; r16 = longint'(y16); end
      if (!busy3 && !busy16) break;
    end
    check($sformatf("w3 y %0h*%0h s%0d", ea3, eb3, s), r3, ref_prod(3, ea3, eb3, s));
    check($sformatf("w3 lat b=%0h", eb3), longint'(e3), longint'(lat(3, eb3, s)));
    check($sformatf("w16 y %0h*%0h s%0d", ea16, eb16, s), r16, ref_prod(16, ea16, eb16, s));
    check($sformatf("w16 lat b=%0h", eb16), longint'(e16), longint'(lat(16, eb16, s)));
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] y;
    string       name;
  } vec_t;

  vec_t tbl [10];

  initial begin
    longint y, y1, y2;
    int ve, vc, bc, n1, v1, v2;
    logic [7:0] ra, rb;
    logic rs;

    tbl[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, "u255x255"};
    tbl[1] = '{8'hFD, 8'h05, 1'b1, 16'hFFF1, "s-3x5"};
    tbl[2] = '{8'h80, 8'h80, 1'b1, 16'h4000, "s-128x-128"};
    tbl[3] = '{8'h80, 8'h80, 1'b0, 16'h4000, "u128x128"};
    tbl[4] = '{8'h5A, 8'h00, 1'b0, 16'h0000, "u_b0"};
    tbl[5] = '{8'h0A, 8'h03, 1'b0, 16'h001E, "u10x3"};
    tbl[6] = '{8'h02, 8'hFF, 1'b1, 16'hFFFE, "s2x-1"};
    tbl[7] = '{8'hFF, 8'hFF, 1'b1, 16'h0001, "s-1x-1"};
    tbl[8] = '{8'h7F, 8'h80, 1'b1, 16'hC080, "s127x-128"};
    tbl[9] = '{8'h00, 8'hFF, 1'b0, 16'h0000, "u0x255"};

    rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; sgn8 = 1'b0;
    start_x = 1'b0; sgn_x = 1'b0; a3 = '0; b3 = '0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    check("reset busy", longint'(busy8), 0);
    check("reset valid", longint'(valid8), 0);
    check("reset y", longint'(y8), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle busy", longint'(busy8), 0);

    for (int i = 0; i < 10; i++) begin
      op8(tbl[i].a, tbl[i].b, tbl[i].s, y, ve, vc, bc);
      n1 = lat(8, longint'(tbl[i].b), tbl[i].s);
      check({tbl[i].name, " y"}, y, longint'(tbl[i].y));
      check({tbl[i].name, " valid edge"}, longint'(ve), longint'(n1));
      check({tbl[i].name, " valid count"}, longint'(vc), 1);
      check({tbl[i].name, " busy cycles"}, longint'(bc), longint'(n1 + 1));
    end

    // start held high with wandering operands; the re-accept uses the then-current inputs
    @(negedge clk);
    a8 = 8'd6; b8 = 8'd7; sgn8 = 1'b0; start8 = 1'b1;
    n1 = lat(8, 7, 1'b0);
    @(posedge clk); #1;
    a8 = 8'($urandom); b8 = 8'($urandom);
    v1 = -1; v2 = -1; y1 = 0; y2 = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (valid8) begin
        if (v1 < 0) begin v1 = k; y1 = longint'(y8); end
        else if (v2 < 0) begin v2 = k; y2 = longint'(y8); end
      end
      if (k < n1 + 1) begin a8 = 8'($urandom); b8 = 8'($urandom); end
      else if (k == n1 + 1) begin a8 = 8'd11; b8 = 8'd13; end
      else if (k == n1 + 2) start8 = 1'b0;
      if (v2 >= 0) break;
    end
    start8 = 1'b0;
    check("held first y", y1, 42);
    check("held first edge", longint'(v1), longint'(n1));
    check("held second y", y2, 143);
    check("held second edge", longint'(v2), longint'(n1 + 2 + lat(8, 13, 1'b0)));
    repeat (12) @(posedge clk);

    // reset in the middle of an operation
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd200; sgn8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst busy", longint'(busy8), 0);
    check("midrst valid", longint'(valid8), 0);
    check("midrst y", longint'(y8), 0);
    @(negedge clk);
    rst = 1'b0;
    vc = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (valid8 || busy8) vc++;
    end
    check("post-reset quiet", longint'(vc), 0);
    op8(8'd100, 8'd200, 1'b0, y, ve, vc, bc);
    check("post-reset y", y, 20000);

    // random sweep
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      if (i % 8 == 0) rb = 8'($urandom_range(0, 3));
      op8(ra, rb, rs, y, ve, vc, bc);
      check($sformatf("w8 y %0h*%0h s%0d", ra, rb, rs), y, ref_prod(8, longint'(ra), longint'(rb), rs));
      check($sformatf("w8 lat b=%0h s%0d", rb, rs), longint'(ve), longint'(lat(8, longint'(rb), rs)));
    end
    for (int i = 0; i < 30; i++) begin
      sweep(1'b0);
      sweep(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
